// File: rtl/qracc_pkg.sv
// Shared qracc types and constants.
// Holds the SRAM request responder state encoding and its wait-state limit.
package qracc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } sram_rq_state_t;

  localparam int SRAM_RQ_MAX_WAIT = 15;

endpackage

// File: rtl/sram_rq_responder.sv
// Digital register-file stand-in for the qracc SRAM request interface.
// Ports: clk/rst, mac_en_i, rq_valid_i/rq_wr_i/addr_i/wr_data_i request in;
// rq_ready_o, rd_valid_o/rd_data_o, wr_done_o, busy_o, err_o,
// wr_count_o/rd_count_o completed-access counters.
module sram_rq_responder
  import qracc_pkg::*;
#(
  parameter int numRows      = 128,
  parameter int numCols      = 32,
  parameter int accessCycles = 2,
  parameter int cntBits      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mac_en_i,
  input  logic                       rq_valid_i,
  input  logic                       rq_wr_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         wr_data_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  output logic                       wr_done_o,
  output logic                       busy_o,
  output logic                       err_o,
  output logic [cntBits-1:0]         wr_count_o,
  output logic [cntBits-1:0]         rd_count_o
);

  localparam int AW = $clog2(numRows);
  localparam logic [AW:0] ROWS = (AW+1)'(numRows);

  if (accessCycles < 1 || accessCycles > SRAM_RQ_MAX_WAIT) begin : g_bad_wait
    $error("sram_rq_responder: accessCycles out of range 1..15");
  end

  sram_rq_state_t     r_state;
  logic [3:0]         r_wait;
  logic               r_wr;
  logic [AW-1:0]      r_addr;
  logic [numCols-1:0] r_wdata;
  logic [numCols-1:0] r_mem [numRows];
  logic               r_rd_valid;
  logic               r_wr_done;
  logic               r_err;
  logic [numCols-1:0] r_rd_data;
  logic [cntBits-1:0] r_wr_cnt;
  logic [cntBits-1:0] r_rd_cnt;

  logic w_accept;
  logic w_complete;
  logic w_in_range;

  assign rq_ready_o = (r_state == S_IDLE) && !mac_en_i && !rst;
  assign w_accept   = rq_valid_i && rq_ready_o;
  assign w_complete = (r_state == S_ACCESS) && (r_wait == 4'd0);
  assign w_in_range = {1'b0, r_addr} < ROWS;

  // Storage is cleared on reset, so it is kept apart from the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < numRows; i++) r_mem[i] <= '0;
    end else if (w_complete && r_wr && w_in_range) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait     <= 4'd0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_valid <= 1'b0;
      r_wr_done  <= 1'b0;
      r_err      <= 1'b0;
      r_rd_data  <= '0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      r_wr_done  <= 1'b0;
      r_err      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr    <= rq_wr_i;
            r_addr  <= addr_i;
            r_wdata <= wr_data_i;
            r_wait  <= 4'(accessCycles - 1);
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_wait == 4'd0) begin
            r_state <= S_RESP;
            r_err   <= !w_in_range;
            if (r_wr) begin
              r_wr_done <= 1'b1;
              r_wr_cnt  <= r_wr_cnt + cntBits'(1);
            end else begin
              r_rd_valid <= 1'b1;
              r_rd_cnt   <= r_rd_cnt + cntBits'(1);
              // Out-of-range reads return zero.
              r_rd_data  <= w_in_range ? r_mem[r_addr] : '0;
            end
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_valid_o = r_rd_valid;
  assign rd_data_o  = r_rd_data;
  assign wr_done_o  = r_wr_done;
  assign err_o      = r_err;
  assign busy_o     = r_state != S_IDLE;
  assign wr_count_o = r_wr_cnt;
  assign rd_count_o = r_rd_cnt;

endmodule

// File: tb/tb_sram_rq_responder.sv
// Randomized self-checking bench for sram_rq_responder.
// Reference: word array plus modular access counts.
module tb_sram_rq_responder;

  localparam int ROWS = 100;
  localparam int COLS = 32;
  localparam int AC   = 2;
  localparam int CB   = 4;
  localparam int AW   = $clog2(ROWS);

  logic            clk = 1'b0;
  logic            rst;
  logic            mac_en;
  logic            rq_valid;
  logic            rq_wr;
  logic [AW-1:0]   addr;
  logic [COLS-1:0] wdata;
  logic            rq_ready;
  logic            rd_valid;
  logic [COLS-1:0] rd_data;
  logic            wr_done;
  logic            busy;
  logic            err;
  logic [CB-1:0]   wr_count;
  logic [CB-1:0]   rd_count;

  always #5 clk = ~clk;

  sram_rq_responder #(
    .numRows(ROWS), .numCols(COLS),
    .accessCycles(AC), .cntBits(CB)
  ) dut (
    .clk(clk), .rst(rst), .mac_en_i(mac_en),
    .rq_valid_i(rq_valid), .rq_wr_i(rq_wr),
    .addr_i(addr), .wr_data_i(wdata),
    .rq_ready_o(rq_ready), .rd_valid_o(rd_valid),
    .rd_data_o(rd_data), .wr_done_o(wr_done),
    .busy_o(busy), .err_o(err),
    .wr_count_o(wr_count), .rd_count_o(rd_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [COLS-1:0] m_mem [ROWS];
  int              m_wrc;
  int              m_rdc;

  task automatic model_reset();
    for (int i = 0; i < ROWS; i++) m_mem[i] = '0;
    m_wrc = 0;
    m_rdc = 0;
  endtask

  task automatic model_apply(input bit wr, input int a,
                             input logic [COLS-1:0] d,
                             output logic [COLS-1:0] exp_rd,
                             output bit exp_err);
    exp_err = (a >= ROWS);
    exp_rd  = '0;
    if (wr) begin
      if (!exp_err) m_mem[a] = d;
      m_wrc = (m_wrc + 1) % (1 << CB);
    end else begin
      if (!exp_err) exp_rd = m_mem[a];
      m_rdc = (m_rdc + 1) % (1 << CB);
    end
  endtask

  // Issues one request and records what the DUT did afterwards.
  // j indexes the negedge after acceptance edge k+j.
  task automatic issue(input bit wr, input int a,
                       input logic [COLS-1:0] d, input int hold,
                       output bit tmo, output int p_at,
                       output int n_p, output int n_oth,
                       output int n_err, output int e_at,
                       output int rdy_lo, output bit rdy_aft,
                       output logic [COLS-1:0] rdat,
                       output logic [COLS-1:0] rhold);
    int n;
    tmo = 0; p_at = -1; n_p = 0; n_oth = 0;
    n_err = 0; e_at = -1; rdy_lo = 0; rdy_aft = 0;
    rdat = 'x; rhold = 'x;
    @(negedge clk);
    rq_wr = wr; addr = AW'(a); wdata = d; rq_valid = 1'b1;
    n = 0;
    while (!rq_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      tmo = 1;
      rq_valid = 1'b0;
      return;
    end
    for (int j = 0; j <= AC + 1; j++) begin
      @(negedge clk);
      if (j >= hold) rq_valid = 1'b0;
      if (j <= AC && !rq_ready) rdy_lo++;
      if (j == AC + 1) begin
        rdy_aft = rq_ready;
        rhold   = rd_data;
      end
      if (wr ? wr_done : rd_valid) begin
        n_p++;
        p_at = j;
        rdat = rd_data;
      end
      if (wr ? rd_valid : wr_done) n_oth++;
      if (err) begin
        n_err++;
        e_at = j;
      end
    end
    rq_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mac_en = 1'b0; rq_valid = 1'b0;
    rq_wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rq_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 0", rq_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({rq_ready, busy, rd_valid, wr_done, err} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 10000",
               {rq_ready, busy, rd_valid, wr_done, err});
    end
    n_cmp++;
    if (rd_data !== '0 || wr_count !== '0 || rd_count !== '0) begin
      n_bad++;
      $display("FAIL reset_regs: got %h/%h/%h want 0/0/0",
               rd_data, wr_count, rd_count);
    end
    model_reset();
  endtask

  task automatic test_write_read();
    bit tmo, rdy_aft, x_err;
    int p_at, n_p, n_oth, n_err, e_at, rdy_lo;
    logic [COLS-1:0] rdat, rhold, x_rd;
    model_apply(1, 5, 32'hDEADBEEF, x_rd, x_err);
    issue(1, 5, 32'hDEADBEEF, 0, tmo, p_at, n_p, n_oth,
          n_err, e_at, rdy_lo, rdy_aft, rdat, rhold);
    n_cmp++;
    if (tmo || p_at != AC || n_p != 1 || n_oth != 0) begin
      n_bad++;
      $display("FAIL wr_pulse: got tmo%0d at%0d n%0d o%0d want 0/%0d/1/0",
               tmo, p_at, n_p, n_oth, AC);
    end
    n_cmp++;
    if (rdy_lo != AC + 1 || rdy_aft !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_ready: got low%0d after%b want %0d/1",
               rdy_lo, rdy_aft, AC + 1);
    end
    model_apply(0, 5, '0, x_rd, x_err);
    issue(0, 5, '0, 0, tmo, p_at, n_p, n_oth,
          n_err, e_at, rdy_lo, rdy_aft, rdat, rhold);
    n_cmp++;
    if (tmo || p_at != AC || n_p != 1 || n_oth != 0 || n_err != 0) begin
      n_bad++;
      $display("FAIL rd_pulse: got tmo%0d at%0d n%0d o%0d e%0d want 0/%0d/1/0/0",
               tmo, p_at, n_p, n_oth, n_err, AC);
    end
    n_cmp++;
    if (rdat !== x_rd || rhold !== x_rd) begin
      n_bad++;
      $display("FAIL rd_data: got %h hold %h want %h", rdat, rhold, x_rd);
    end
  endtask

  task automatic test_extended_valid();
    bit tmo, rdy_aft, x_err;
    int p_at, n_p, n_oth, n_err, e_at, rdy_lo;
    logic [COLS-1:0] rdat, rhold, x_rd, d;
    d = $urandom;
    model_apply(1, 9, d, x_rd, x_err);
    issue(1, 9, d, AC + 1, tmo, p_at, n_p, n_oth,
          n_err, e_at, rdy_lo, rdy_aft, rdat, rhold);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tmo || n_p != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ext_single: got tmo%0d n%0d busy%b want 0/1/0",
               tmo, n_p, busy);
    end
    n_cmp++;
    if (wr_count !== CB'(m_wrc)) begin
      n_bad++;
      $display("FAIL ext_wrcount: got %0d want %0d", wr_count, m_wrc);
    end
  endtask

  task automatic test_fill();
    bit tmo, rdy_aft, x_err;
    int p_at, n_p, n_oth, n_err, e_at, rdy_lo, bad;
    logic [COLS-1:0] rdat, rhold, x_rd, d;
    for (int a = 0; a < ROWS; a++) begin
      d = $urandom;
      model_apply(1, a, d, x_rd, x_err);
      issue(1, a, d, $urandom_range(0, AC + 1), tmo, p_at, n_p,
            n_oth, n_err, e_at, rdy_lo, rdy_aft, rdat, rhold);
    end
    bad = 0;
    for (int a = 0; a < ROWS; a++) begin
      model_apply(0, a, '0, x_rd, x_err);
      issue(0, a, '0, 0, tmo, p_at, n_p, n_oth,
            n_err, e_at, rdy_lo, rdy_aft, rdat, rhold);
      n_cmp++;
      if (tmo || n_p != 1 || rdat !== x_rd) begin
        n_bad++;
        bad++;
        if (bad < 5)
          $display("FAIL fill_rd[%0d]: got %h tmo%0d n%0d want %h",
                   a, rdat, tmo, n_p, x_rd);
      end
    end
    n_cmp++;
    if (wr_count !== CB'(m_wrc) || rd_count !== CB'(m_rdc)) begin
      n_bad++;
      $display("FAIL fill_counts: got %0d/%0d want %0d/%0d",
               wr_count, rd_count, m_wrc, m_rdc);
    end
  endtask

  task automatic test_out_of_range();
    bit tmo, rdy_aft, x_err;
    int p_at, n_p, n_oth, n_err, e_at, rdy_lo, w0, r0;
    logic [COLS-1:0] rdat, rhold, x_rd, d;
    w0 = m_wrc; r0 = m_rdc;
    d = $urandom;
    model_apply(1, 110, d, x_rd, x_err);
    issue(1, 110, d, 0, tmo, p_at, n_p, n_oth,
          n_err, e_at, rdy_lo, rdy_aft, rdat, rhold);
    n_cmp++;
    if (tmo || n_p != 1 || n_err != 1 || e_at != AC) begin
      n_bad++;
      $display("FAIL oor_wr_err: got n%0d e%0d at%0d want 1/1/%0d",
               n_p, n_err, e_at, AC);
    end
    model_apply(0, 110, '0, x_rd, x_err);
    issue(0, 110, '0, 0, tmo, p_at, n_p, n_oth,
          n_err, e_at, rdy_lo, rdy_aft, rdat, rhold);
    n_cmp++;
    if (tmo || n_err != 1 || e_at != AC || rdat !== '0) begin
      n_bad++;
      $display("FAIL oor_rd: got e%0d at%0d data %h want 1/%0d/0",
               n_err, e_at, rdat, AC);
    end
    n_cmp++;
    if (wr_count !== CB'(w0 + 1) || rd_count !== CB'(r0 + 1)) begin
      n_bad++;
      $display("FAIL oor_counts: got %0d/%0d want %0d/%0d",
               wr_count, rd_count, (w0 + 1) % 16, (r0 + 1) % 16);
    end
  endtask

  task automatic test_random();
    bit tmo, rdy_aft, x_err, wr;
    int p_at, n_p, n_oth, n_err, e_at, rdy_lo, a, bad;
    logic [COLS-1:0] rdat, rhold, x_rd, d;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      wr = $urandom_range(0, 1);
      a  = (i % 4 == 0) ? $urandom_range(0, 127) : $urandom_range(0, ROWS - 1);
      d  = $urandom;
      model_apply(wr, a, d, x_rd, x_err);
      issue(wr, a, d, $urandom_range(0, AC + 1), tmo, p_at, n_p,
            n_oth, n_err, e_at, rdy_lo, rdy_aft, rdat, rhold);
      n_cmp++;
      if (tmo || p_at != AC || n_p != 1 || n_oth != 0 ||
          n_err != int'(x_err) || (!wr && rdat !== x_rd) ||
          wr_count !== CB'(m_wrc) || rd_count !== CB'(m_rdc)) begin
        n_bad++;
        bad++;
        if (bad < 5)
          $display("FAIL rand[%0d]: wr%0d a%0d got %h e%0d c%0d/%0d want %h e%0d c%0d/%0d",
                   i, wr, a, rdat, n_err, wr_count, rd_count,
                   x_rd, x_err, m_wrc, m_rdc);
      end
    end
  endtask

  task automatic test_mac_block();
    bit tmo, rdy_aft, x_err;
    int p_at, n_p, n_oth, n_err, e_at, rdy_lo, lo;
    logic [COLS-1:0] rdat, rhold, x_rd, d;
    d = $urandom;
    @(negedge clk);
    mac_en = 1'b1;
    rq_wr = 1'b1; addr = AW'(7); wdata = d; rq_valid = 1'b1;
    lo = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rq_ready && !busy) lo++;
    end
    n_cmp++;
    if (lo != 10) begin
      n_bad++;
      $display("FAIL mac_block: got %0d idle-blocked cycles want 10", lo);
    end
    mac_en = 1'b0;
    #1;
    n_cmp++;
    if (rq_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mac_release: got ready %b want 1", rq_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mac_accept: got busy %b want 1", busy);
    end
    rq_valid = 1'b0;
    model_apply(1, 7, d, x_rd, x_err);
    repeat (AC + 1) @(negedge clk);
    model_apply(0, 7, '0, x_rd, x_err);
    issue(0, 7, '0, 0, tmo, p_at, n_p, n_oth,
          n_err, e_at, rdy_lo, rdy_aft, rdat, rhold);
    n_cmp++;
    if (tmo || rdat !== x_rd || wr_count !== CB'(m_wrc)) begin
      n_bad++;
      $display("FAIL mac_data: got %h cnt %0d want %h cnt %0d",
               rdat, wr_count, x_rd, m_wrc);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    rq_wr = 1'b1; addr = AW'(3); wdata = 32'h55; rq_valid = 1'b1;
    @(negedge clk);
    rq_valid = 1'b0;
    rst = 1'b1;
    seen = 0;
    @(negedge clk);
    if (wr_done) seen++;
    n_cmp++;
    if (rq_ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_hold: got ready %b busy %b want 0/0",
               rq_ready, busy);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rq_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_ready: got %b want 1", rq_ready);
    end
    repeat (AC + 2) begin
      @(negedge clk);
      if (wr_done) seen++;
    end
    n_cmp++;
    if (seen != 0 || wr_count !== '0 || rd_count !== '0) begin
      n_bad++;
      $display("FAIL rstmid_abort: got done%0d cnt %0d/%0d want 0 0/0",
               seen, wr_count, rd_count);
    end
    model_reset();
  endtask

  task automatic test_wrap();
    bit tmo, rdy_aft, x_err;
    int p_at, n_p, n_oth, n_err, e_at, rdy_lo, a, bad;
    logic [COLS-1:0] rdat, rhold, x_rd, last;
    bad = 0;
    last = '0;
    for (int i = 0; i < 17; i++) begin
      a = (i == 0) ? 3 : $urandom_range(0, ROWS - 1);
      model_apply(0, a, '0, x_rd, x_err);
      issue(0, a, '0, 0, tmo, p_at, n_p, n_oth,
            n_err, e_at, rdy_lo, rdy_aft, rdat, rhold);
      last = x_rd;
      if (tmo || rdat !== x_rd || rhold !== x_rd) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL wrap_data: got %0d bad reads want 0", bad);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rd_count !== CB'(1) || rd_count !== CB'(m_rdc)) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d want 1", rd_count);
    end
    n_cmp++;
    if (rd_data !== last) begin
      n_bad++;
      $display("FAIL wrap_hold: got %h want %h", rd_data, last);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_extended_valid();
    test_fill();
    test_out_of_range();
    test_random();
    test_mac_block();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
